// File: rtl/mem_line_arbiter_pkg.sv
// Shared types, widths and address helpers for the line-RAM arbiter.
package mem_arb_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_OFF_W = $clog2(LINE_BYTES);
    localparam int RAM_WIN_W  = 9;
    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 32;
    localparam int LAT_W      = 4;
    localparam int STARVE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

    // Bit 31 is deliberately outside the window test; only [30:9] must be zero.
    function automatic logic out_of_window(input logic [ADDR_W-1:0] a);
        return |a[ADDR_W-2:RAM_WIN_W];
    endfunction

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Demand/prefetch request+response channels and the line-RAM port.
// Handshake: a request transfers on a rising edge where valid & ready are both 1;
// ready may depend combinationally on valid; responses have no backpressure.
interface mem_line_arbiter_if;
    import mem_arb_pkg::*;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              p_req_valid;
    logic              p_req_ready;
    logic [ADDR_W-1:0] p_addr;
    logic              p_resp_valid;
    logic [DATA_W-1:0] p_rdata;
    logic              p_err;

    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              wea;
    logic [DATA_W-1:0] douta;

    // master = requesters plus the RAM; slave = the arbiter
    modport master (
        output d_req_valid, d_addr, d_we, d_wdata, p_req_valid, p_addr, douta,
        input  d_req_ready, d_resp_valid, d_rdata, d_err,
        input  p_req_ready, p_resp_valid, p_rdata, p_err, addra, dina, wea
    );

    modport slave (
        input  d_req_valid, d_addr, d_we, d_wdata, p_req_valid, p_addr, douta,
        output d_req_ready, d_resp_valid, d_rdata, d_err,
        output p_req_ready, p_resp_valid, p_rdata, p_err, addra, dina, wea
    );

endinterface

// File: rtl/mem_lat_timer.sv
// Down-counter timing the BUSY phase; o_done marks the final BUSY cycle.
module mem_lat_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_done
);

    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LAT_W'(LATENCY);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LAT_W'(1);
        end
    end

    assign o_done = (r_cnt == LAT_W'(1));

endmodule

// File: rtl/mem_line_arbiter.sv
// Single-transaction line-RAM arbiter: demand priority with prefetch anti-starvation
// and merging of a matching demand read into an in-flight prefetch read.
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clka,
    input  logic              rst_n,
    mem_line_arbiter_if.slave bus,
    output state_t            dbg_state
);

    state_t              r_state;
    logic [STARVE_W-1:0] r_starve;
    logic                r_owner_p;
    logic                r_we;
    logic                r_oow;
    logic                r_merged;
    logic [ADDR_W-1:0]   r_line;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_d_resp_valid;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_d_err;
    logic                r_p_resp_valid;
    logic [DATA_W-1:0]   r_p_rdata;
    logic                r_p_err;

    logic                w_done;
    logic                w_force_p;
    logic                w_grant_d;
    logic                w_grant_p;
    logic                w_merge;
    logic                w_wea;
    logic [DATA_W-1:0]   w_rdata;

    mem_lat_timer #(.LATENCY(LATENCY)) u_timer (
        .i_clk   (clka),
        .i_rst_n (rst_n),
        .i_load  (w_grant_d | w_grant_p),
        .o_done  (w_done)
    );

    assign w_force_p = (r_starve == STARVE_W'(STARVE_MAX)) && bus.p_req_valid;
    assign w_grant_d = (r_state == ST_IDLE) && bus.d_req_valid && !w_force_p;
    assign w_grant_p = (r_state == ST_IDLE) && bus.p_req_valid && !w_grant_d;
    assign w_merge   = (r_state == ST_BUSY) && r_owner_p && !r_merged && bus.d_req_valid
                       && !bus.d_we && (line_addr(bus.d_addr) == r_line);
    assign w_wea     = (r_state == ST_BUSY) && w_done && r_we && !r_oow;
    assign w_rdata   = (r_we || r_oow) ? '0 : bus.douta;

    assign bus.d_req_ready  = w_grant_d | w_merge;
    assign bus.p_req_ready  = w_grant_p;
    assign bus.addra        = (r_state == ST_BUSY) ? r_line : '0;
    assign bus.wea          = w_wea;
    assign bus.dina         = w_wea ? r_wdata : '0;
    assign bus.d_resp_valid = r_d_resp_valid;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_err        = r_d_err;
    assign bus.p_resp_valid = r_p_resp_valid;
    assign bus.p_rdata      = r_p_rdata;
    assign bus.p_err        = r_p_err;
    assign dbg_state        = r_state;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_starve       <= '0;
            r_owner_p      <= 1'b0;
            r_we           <= 1'b0;
            r_oow          <= 1'b0;
            r_merged       <= 1'b0;
            r_line         <= '0;
            r_wdata        <= '0;
            r_d_resp_valid <= 1'b0;
            r_d_rdata      <= '0;
            r_d_err        <= 1'b0;
            r_p_resp_valid <= 1'b0;
            r_p_rdata      <= '0;
            r_p_err        <= 1'b0;
        end else begin
            r_d_resp_valid <= 1'b0;
            r_p_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= ST_BUSY;
                        r_owner_p <= 1'b0;
                        r_we      <= bus.d_we;
                        r_oow     <= out_of_window(bus.d_addr);
                        r_line    <= line_addr(bus.d_addr);
                        r_wdata   <= bus.d_wdata;
                        r_merged  <= 1'b0;
                        if (bus.p_req_valid && (r_starve != {STARVE_W{1'b1}}))
                            r_starve <= r_starve + STARVE_W'(1);
                    end else if (w_grant_p) begin
                        r_state   <= ST_BUSY;
                        r_owner_p <= 1'b1;
                        r_we      <= 1'b0;
                        r_oow     <= out_of_window(bus.p_addr);
                        r_line    <= line_addr(bus.p_addr);
                        r_wdata   <= '0;
                        r_merged  <= 1'b0;
                        r_starve  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (w_merge)
                        r_merged <= 1'b1;
                    if (w_done) begin
                        r_state <= ST_RESP;
                        // A demand merged on the very last BUSY cycle still rides this response.
                        if (!r_owner_p || r_merged || w_merge) begin
                            r_d_resp_valid <= 1'b1;
                            r_d_rdata      <= w_rdata;
                            r_d_err        <= r_oow;
                        end
                        if (r_owner_p) begin
                            r_p_resp_valid <= 1'b1;
                            r_p_rdata      <= w_rdata;
                            r_p_err        <= r_oow;
                        end
                    end
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    r_merged <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: scoreboarded vector table plus
// hand sequences for latency, merge, starvation order and mid-write reset.
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT  = 4;
  localparam int SMAX = 2;

  logic   clka = 1'b0;
  logic   rst_n = 1'b0;
  logic   ram_load = 1'b1;
  state_t dbg_state;

  mem_line_arbiter_if bus();

  mem_line_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clka = ~clka;

  function automatic logic [127:0] init_line(input int k);
    logic [127:0] l;
    for (int j = 0; j < 16; j++) l[8*j +: 8] = 8'((k * 16 + j) & 255);
    return l;
  endfunction

  logic [127:0] ram [32];
  logic [127:0] shadow [32];

  always @(posedge clka) begin
    if (ram_load) begin
      for (int k = 0; k < 32; k++) ram[k] <= init_line(k);
    end else if (bus.wea) begin
      ram[bus.addra[8:4]] <= bus.dina;
    end
  end
  assign bus.douta = ram[bus.addra[8:4]];

  // ---------------- scoreboard ----------------
  typedef struct {
    logic         we;
    logic [31:0]  line;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         err;
  } exp_t;

  exp_t d_exp_q[$];
  exp_t p_exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int d_hs_cyc, p_hs_cyc, d_resp_cyc, p_resp_cyc;
  int d_resp_cnt = 0, p_resp_cnt = 0, both_cnt = 0, wea_cnt = 0, addra_cnt = 0;
  logic [31:0] last_wea_addr, last_addra;
  logic last_d_err, last_p_err;
  bit grant_log[$];
  int grant_cyc[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic exp_t predict(input logic we, input logic [31:0] a, input logic [127:0] wd);
    exp_t e;
    e.we    = we;
    e.line  = {a[31:4], 4'h0};
    e.wdata = wd;
    e.err   = |a[30:9];
    e.rdata = (we || e.err) ? 128'h0 : shadow[a[8:4]];
    return e;
  endfunction

  always @(posedge clka) cyc++;

  always @(negedge clka) begin
    if (rst_n) begin
      if (bus.d_req_valid && bus.d_req_ready) begin
        d_exp_q.push_back(predict(bus.d_we, bus.d_addr, bus.d_wdata));
        d_hs_cyc = cyc;
        grant_log.push_back(1'b0);
        grant_cyc.push_back(cyc);
      end
      if (bus.p_req_valid && bus.p_req_ready) begin
        p_exp_q.push_back(predict(1'b0, bus.p_addr, 128'h0));
        p_hs_cyc = cyc;
        grant_log.push_back(1'b1);
        grant_cyc.push_back(cyc);
      end
      if (bus.wea) begin
        wea_cnt++;
        last_wea_addr = bus.addra;
      end
      if (bus.addra != 32'h0) begin
        addra_cnt++;
        last_addra = bus.addra;
      end
      if (bus.d_resp_valid && bus.p_resp_valid) both_cnt++;
      if (bus.d_resp_valid) begin
        d_resp_cnt++;
        d_resp_cyc = cyc;
        last_d_err = bus.d_err;
        if (d_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL d_resp_unexpected actual=1 required=0");
        end else begin
          mon_e = d_exp_q.pop_front();
          check("d_rdata", bus.d_rdata, mon_e.rdata);
          check("d_err", 128'(bus.d_err), 128'(mon_e.err));
          if (mon_e.we && !mon_e.err) shadow[mon_e.line[8:4]] = mon_e.wdata;
        end
      end
      if (bus.p_resp_valid) begin
        p_resp_cnt++;
        p_resp_cyc = cyc;
        last_p_err = bus.p_err;
        if (p_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL p_resp_unexpected actual=1 required=0");
        end else begin
          mon_e = p_exp_q.pop_front();
          check("p_rdata", bus.p_rdata, mon_e.rdata);
          check("p_err", 128'(bus.p_err), 128'(mon_e.err));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_d(input logic we, input logic [31:0] a, input logic [127:0] wd);
    bit ok = 0;
    @(posedge clka); #1;
    bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clka);
      if (bus.d_req_ready) begin ok = 1; break; end
    end
    @(posedge clka); #1;
    bus.d_req_valid = 1'b0;
    if (!ok) begin checks++; failures++; $display("FAIL d_handshake_timeout actual=0 required=1"); end
  endtask

  task automatic send_p(input logic [31:0] a);
    bit ok = 0;
    @(posedge clka); #1;
    bus.p_addr = a; bus.p_req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clka);
      if (bus.p_req_ready) begin ok = 1; break; end
    end
    @(posedge clka); #1;
    bus.p_req_valid = 1'b0;
    if (!ok) begin checks++; failures++; $display("FAIL p_handshake_timeout actual=0 required=1"); end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clka); #2;
      if (d_exp_q.size() == 0 && p_exp_q.size() == 0 && dbg_state == ST_IDLE) begin ok = 1; break; end
    end
    if (!ok) begin checks++; failures++; $display("FAIL resp_timeout actual=0 required=1"); end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         is_p;
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         exp_err;
    logic         exp_wea;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic is_p, input logic we, input logic [31:0] a,
                              input logic [127:0] wd, input logic err, input logic wea);
    vec_t v;
    v.is_p = is_p; v.we = we; v.addr = a; v.wdata = wd; v.exp_err = err; v.exp_wea = wea;
    return v;
  endfunction

  initial begin : watchdog
    repeat (20000) @(posedge clka);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wea0, d0, both0, cnt;
    bit ok, expp;
    logic [127:0] rnd_a, rnd_b;

    rnd_a = {$urandom, $urandom, $urandom, $urandom};
    rnd_b = {$urandom, $urandom, $urandom, $urandom};
    tbl[0]  = mk(0, 0, 32'h0000_0013, 128'h0,        0, 0);
    tbl[1]  = mk(0, 1, 32'h0000_0020, {16{8'hA5}},   0, 1);
    tbl[2]  = mk(0, 0, 32'h0000_002F, 128'h0,        0, 0);
    tbl[3]  = mk(1, 0, 32'h0000_0040, 128'h0,        0, 0);
    tbl[4]  = mk(0, 0, 32'h0000_0200, 128'h0,        1, 0);
    tbl[5]  = mk(0, 1, 32'h0000_0204, rnd_a,         1, 0);
    tbl[6]  = mk(1, 0, 32'h0000_01F0, 128'h0,        0, 0);
    tbl[7]  = mk(1, 0, 32'h0000_0400, 128'h0,        1, 0);
    tbl[8]  = mk(0, 1, 32'h0000_01F8, rnd_b,         0, 1);
    tbl[9]  = mk(0, 0, 32'h0000_01F0, 128'h0,        0, 0);
    tbl[10] = mk(0, 0, 32'h0001_0010, 128'h0,        1, 0);
    tbl[11] = mk(1, 0, 32'h0000_0013, 128'h0,        0, 0);

    for (int k = 0; k < 32; k++) shadow[k] = init_line(k);
    bus.d_req_valid = 0; bus.d_addr = 0; bus.d_we = 0; bus.d_wdata = 0;
    bus.p_req_valid = 0; bus.p_addr = 0;

    // reset state
    repeat (3) @(posedge clka);
    #1 ram_load = 1'b0;
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    check("rst_addra", 128'(bus.addra), 128'h0);
    check("rst_wea", 128'(bus.wea), 128'h0);
    check("rst_d_resp_valid", 128'(bus.d_resp_valid), 128'h0);
    check("rst_p_rdata", bus.p_rdata, 128'h0);
    @(negedge clka); rst_n = 1'b1;

    // demand read latency and RAM port timing
    addra_cnt = 0;
    send_d(0, 32'h0000_0013, 128'h0);
    wait_done();
    check("lat_resp_cycles", 128'(d_resp_cyc - d_hs_cyc), 128'(LAT + 1));
    check("lat_addra_cycles", 128'(addra_cnt), 128'(LAT));
    check("lat_addra_value", 128'(last_addra), 128'h10);
    check("lat_rdata", bus.d_rdata, init_line(1));

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      wea0 = wea_cnt;
      if (tbl[i].is_p) send_p(tbl[i].addr);
      else send_d(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      wait_done();
      check($sformatf("tbl%0d_err", i), 128'(tbl[i].is_p ? last_p_err : last_d_err), 128'(tbl[i].exp_err));
      check($sformatf("tbl%0d_wea_cnt", i), 128'(wea_cnt - wea0), 128'(tbl[i].exp_wea));
      if (tbl[i].exp_wea)
        check($sformatf("tbl%0d_wea_addr", i), 128'(last_wea_addr), 128'({tbl[i].addr[31:4], 4'h0}));
    end

    // demand read merged into an in-flight prefetch of the same line
    both0 = both_cnt;
    fork
      send_p(32'h0000_0040);
      begin @(posedge clka); send_d(0, 32'h0000_004C, 128'h0); end
    join
    wait_done();
    check("merge_accept_cycle", 128'(d_hs_cyc - p_hs_cyc), 128'd1);
    check("merge_same_resp_cycle", 128'(d_resp_cyc), 128'(p_resp_cyc));
    check("merge_both_valid", 128'(both_cnt - both0), 128'd1);
    check("merge_d_rdata", bus.d_rdata, init_line(4));

    // demand write to the same line must wait for IDLE
    both0 = both_cnt;
    fork
      send_p(32'h0000_0040);
      begin @(posedge clka); send_d(1, 32'h0000_0040, {16{8'h3C}}); end
    join
    wait_done();
    check("nomerge_write_wait", 128'(d_hs_cyc - p_resp_cyc), 128'd1);
    check("nomerge_both_valid", 128'(both_cnt - both0), 128'd0);

    // reset in the last BUSY cycle of a write
    d0 = d_resp_cnt;
    send_d(1, 32'h0000_0060, {128{1'b1}});
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clka);
      if (bus.wea) begin ok = 1; break; end
    end
    check("rstw_wea_seen", 128'(ok), 128'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_wea", 128'(bus.wea), 128'h0);
    check("rstw_addra", 128'(bus.addra), 128'h0);
    check("rstw_dina", bus.dina, 128'h0);
    check("rstw_state", 128'(dbg_state), 128'(ST_IDLE));
    check("rstw_p_rdata", bus.p_rdata, 128'h0);
    d_exp_q.delete();
    p_exp_q.delete();
    repeat (2) @(posedge clka);
    @(negedge clka); rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clka);
    #1;
    check("rstw_no_resp", 128'(d_resp_cnt - d0), 128'd0);
    check("rstw_ram_kept", ram[6], init_line(6));
    send_d(0, 32'h0000_0060, 128'h0);
    wait_done();
    check("rstw_read_after", bus.d_rdata, init_line(6));

    // both requesters valid continuously: starvation-driven grant order
    grant_log.delete();
    grant_cyc.delete();
    @(posedge clka); #1;
    bus.d_we = 0; bus.d_addr = 32'h0000_0100; bus.p_addr = 32'h0000_0080;
    bus.d_req_valid = 1'b1; bus.p_req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clka); #1;
      if (grant_log.size() >= 20) break;
    end
    bus.d_req_valid = 1'b0; bus.p_req_valid = 1'b0;
    wait_done();
    check("arb_grants", 128'(grant_log.size()), 128'd20);
    cnt = 0;
    for (int n = 0; n < grant_log.size(); n++) begin
      expp = (cnt == SMAX);
      if (expp) cnt = 0; else cnt++;
      check($sformatf("arb_order%0d", n), 128'(grant_log[n]), 128'(expp));
    end
    if (grant_cyc.size() == 20)
      check("arb_throughput", 128'(grant_cyc[19] - grant_cyc[0]), 128'(19 * (LAT + 2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
